// File: rtl/pwm_precon_pkg.sv
// Shared types and constants for the PWM preconditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_precon_pkg;

  localparam int WIDTH        = 13;
  localparam int DEPTH        = 249;
  localparam int IDX_W        = $clog2(DEPTH);
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, COMMIT} state_t;

  // Per-entry output class decided in stage 1, consumed in stage 2.
  typedef enum logic [1:0] {M_ZERO, M_OFF, M_ON, M_NORM} mode_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } calc_t;

  // Phase limited to the last tick of the period; cycle==0 is handled separately.
  function automatic logic [WIDTH-1:0] clamp_phase(input logic [WIDTH-1:0] phase,
                                                   input logic [WIDTH-1:0] cyc);
    if (phase >= cyc) return cyc - WIDTH'(1);
    return phase;
  endfunction

endpackage

// File: rtl/pwm_precon_calc.sv
// Two-stage duty/phase to rise/fall converter: stage 1 clamps and halves, stage 2 wraps.
// Latency: 2 cycles from i_vld to o_vld, one entry per cycle.
// Backpressure: none; caller issues at most one entry per cycle.
module pwm_precon_calc
  import pwm_precon_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_cycle,
  input  logic [WIDTH-1:0] i_duty,
  input  logic [WIDTH-1:0] i_phase,
  output logic             o_vld,
  output calc_t            o_res
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  mode_t            w_mode;

  logic             r_s1_vld;
  logic [IDX_W-1:0] r_s1_idx;
  logic [WIDTH-1:0] r_s1_c;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_lo;
  logic [WIDTH-1:0] r_s1_hi;
  mode_t            r_s1_mode;

  logic [WIDTH-1:0] w_c_minus_p;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  logic             r_vld;
  calc_t            r_res;

  assign w_p  = clamp_phase(i_phase, i_cycle);
  assign w_lo = i_duty >> 1;
  assign w_hi = i_duty - w_lo;

  // Stage 1 classification: zero period, always off, always on, or a real pulse.
  always_comb begin
    w_mode = M_NORM;
    if (i_cycle == '0)       w_mode = M_ZERO;
    else if (i_duty == '0)   w_mode = M_OFF;
    else if (i_duty >= i_cycle) w_mode = M_ON;
  end

  // Stage 1 register: clamped phase, half-widths and class.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_idx  <= '0;
      r_s1_c    <= '0;
      r_s1_p    <= '0;
      r_s1_lo   <= '0;
      r_s1_hi   <= '0;
      r_s1_mode <= M_ZERO;
    end else begin
      r_s1_vld  <= i_vld;
      r_s1_idx  <= i_idx;
      r_s1_c    <= i_cycle;
      r_s1_p    <= w_p;
      r_s1_lo   <= w_lo;
      r_s1_hi   <= w_hi;
      r_s1_mode <= w_mode;
    end
  end

  // Distance from phase to the period end; p < C in the pulse case so it never underflows.
  assign w_c_minus_p = r_s1_c - r_s1_p;

  // Stage 2 wrap: p-lo and p+hi folded back into [0, C) without needing an extra bit.
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    case (r_s1_mode)
      M_ZERO: begin
        w_rise = '0;
        w_fall = '0;
      end
      M_OFF: begin
        w_rise = r_s1_p;
        w_fall = r_s1_p;
      end
      M_ON: begin
        w_rise = '0;
        w_fall = r_s1_c;
      end
      default: begin
        w_rise = (r_s1_p < r_s1_lo) ? r_s1_p + (r_s1_c - r_s1_lo) : r_s1_p - r_s1_lo;
        w_fall = (r_s1_hi >= w_c_minus_p) ? r_s1_hi - w_c_minus_p : r_s1_p + r_s1_hi;
      end
    endcase
  end

  // Stage 2 register: result tagged with its transducer index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_res <= '0;
    end else begin
      r_vld      <= r_s1_vld;
      r_res.idx  <= r_s1_idx;
      r_res.rise <= w_rise;
      r_res.fall <= w_fall;
    end
  end

  assign o_vld = r_vld;
  assign o_res = r_res;

endmodule

// File: rtl/pwm_preconditioner.sv
// Per-period rise/fall compare-time generator for all transducers, committed atomically.
// Latency: START edge sampled in cycle t -> UPDATE in cycle t+DEPTH+3; RISE/FALL load at the end of that cycle.
// Backpressure: none; an edge during a pass is dropped and flagged on OVERRUN. Optional macro PWM_PRECON_FORCE_OFF_EN.
module pwm_preconditioner
  import pwm_precon_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_start,
`ifdef PWM_PRECON_FORCE_OFF_EN
  input  logic                        i_force_off,
`endif
  input  logic [DEPTH-1:0][WIDTH-1:0] i_cycle,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_duty,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_phase,
  output logic [DEPTH-1:0][WIDTH-1:0] o_rise,
  output logic [DEPTH-1:0][WIDTH-1:0] o_fall,
  output logic                        o_update,
  output logic                        o_busy,
  output logic                        o_overrun
);

  logic                        r_start_q;
  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [DRAIN_W-1:0]          r_drain_cnt;
  logic                        r_busy;
  logic                        r_update;
  logic [DEPTH-1:0][WIDTH-1:0] r_shadow_rise;
  logic [DEPTH-1:0][WIDTH-1:0] r_shadow_fall;
  logic [DEPTH-1:0][WIDTH-1:0] r_rise;
  logic [DEPTH-1:0][WIDTH-1:0] r_fall;

  logic                        w_edge;
  logic                        w_issue;
  logic                        w_calc_vld;
  calc_t                       w_calc_res;

  assign w_edge  = i_start & ~r_start_q;
  assign w_issue = (r_state == CALC);

  // START history for rising-edge detection, tracked regardless of state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_start_q <= 1'b0;
    else          r_start_q <= i_start;
  end

  // Pass sequencer: issue every index, flush the pipeline, then commit for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_edge && i_enable) begin
            r_state <= CALC;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CALC: begin
          if (r_idx == LAST_IDX) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == LAST_DRAIN) begin
            r_state  <= COMMIT;
            r_update <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  pwm_precon_calc u_calc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (w_issue),
    .i_idx   (r_idx),
    .i_cycle (i_cycle[r_idx]),
    .i_duty  (i_duty[r_idx]),
    .i_phase (i_phase[r_idx]),
    .o_vld   (w_calc_vld),
    .o_res   (w_calc_res)
  );

  // Shadow set collects results as they leave the pipeline; last write lands in the final DRAIN cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_rise <= '0;
      r_shadow_fall <= '0;
    end else if (w_calc_vld) begin
      r_shadow_rise[w_calc_res.idx] <= w_calc_res.rise;
      r_shadow_fall[w_calc_res.idx] <= w_calc_res.fall;
    end
  end

  // Atomic commit of the whole set at the end of the COMMIT cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else if (r_state == COMMIT) begin
`ifdef PWM_PRECON_FORCE_OFF_EN
      if (i_force_off) begin
        r_rise <= '0;
        r_fall <= '0;
      end else begin
        r_rise <= r_shadow_rise;
        r_fall <= r_shadow_fall;
      end
`else
      r_rise <= r_shadow_rise;
      r_fall <= r_shadow_fall;
`endif
    end
  end

  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_update = r_update;
  assign o_busy   = r_busy;
  // Flagged in the same cycle the rejected edge is seen, so it lines up with the offending START.
  assign o_overrun = w_edge & r_busy;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed bench for pwm_preconditioner: vector table mapped across all transducers.
// Latency: checks UPDATE arrival relative to the START edge.
// Backpressure: exercises OVERRUN, ENABLE gating and mid-pass reset.
module tb_pwm_preconditioner;
  import pwm_precon_pkg::*;

  typedef struct {
    int cyc;
    int duty;
    int phase;
    int rise;
    int fall;
  } vec_t;

  localparam int NV = 13;

  logic                        clk;
  logic                        rst_n;
  logic                        enable;
  logic                        start;
`ifdef PWM_PRECON_FORCE_OFF_EN
  logic                        force_off;
`endif
  logic [DEPTH-1:0][WIDTH-1:0] cyc;
  logic [DEPTH-1:0][WIDTH-1:0] duty;
  logic [DEPTH-1:0][WIDTH-1:0] phase;
  logic [DEPTH-1:0][WIDTH-1:0] rise;
  logic [DEPTH-1:0][WIDTH-1:0] fall;
  logic                        update;
  logic                        busy;
  logic                        overrun;

  vec_t tv [NV];
  int   exp_rise [DEPTH];
  int   exp_fall [DEPTH];
  int   n_pass;
  int   n_total;

  pwm_preconditioner dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (enable),
    .i_start   (start),
`ifdef PWM_PRECON_FORCE_OFF_EN
    .i_force_off (force_off),
`endif
    .i_cycle   (cyc),
    .i_duty    (duty),
    .i_phase   (phase),
    .o_rise    (rise),
    .o_fall    (fall),
    .o_update  (update),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic load_inputs(input int rot);
    for (int i = 0; i < DEPTH; i++) begin
      int k;
      k = (i + rot) % NV;
      cyc[i]   = WIDTH'(tv[k].cyc);
      duty[i]  = WIDTH'(tv[k].duty);
      phase[i] = WIDTH'(tv[k].phase);
    end
  endtask

  task automatic expect_commit(input int rot);
    for (int i = 0; i < DEPTH; i++) begin
      exp_rise[i] = tv[(i + rot) % NV].rise;
      exp_fall[i] = tv[(i + rot) % NV].fall;
    end
  endtask

  task automatic expect_zero();
    for (int i = 0; i < DEPTH; i++) begin
      exp_rise[i] = 0;
      exp_fall[i] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s rise[%0d]", tag, i), int'(rise[i]), exp_rise[i]);
      chk($sformatf("%s fall[%0d]", tag, i), int'(fall[i]), exp_fall[i]);
    end
  endtask

  // One START edge, observed over a fixed window long enough for a full pass.
  task automatic run_pass(input string tag, input int rot, input bit en0,
                          input int second_at, input int drop_at);
    int upd_cnt, first_upd, ovr_cnt, busy_cnt;
    bit ovr_at_second;
    upd_cnt = 0; first_upd = -1; ovr_cnt = 0; busy_cnt = 0; ovr_at_second = 1'b0;
    load_inputs(rot);
    enable = en0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int n = 1; n <= DEPTH + 13; n++) begin
      @(posedge clk); #1;
      if (n == 3) start = 1'b0;
      if (second_at > 0 && n == second_at) start = 1'b1;
      if (second_at > 0 && n == second_at + 2) start = 1'b0;
      if (drop_at > 0 && n == drop_at) enable = 1'b0;
      #1;
      if (update) begin
        upd_cnt++;
        if (first_upd < 0) first_upd = n;
      end
      if (overrun) begin
        ovr_cnt++;
        if (n == second_at) ovr_at_second = 1'b1;
      end
      if (busy) busy_cnt++;
    end
    enable = 1'b1;
    if (en0) expect_commit(rot);
    chk({tag, " update_count"}, upd_cnt, en0 ? 1 : 0);
    if (en0) chk({tag, " update_latency"}, first_upd, DEPTH + 3);
    chk({tag, " busy_cycles"}, busy_cnt, en0 ? DEPTH + 3 : 0);
    chk({tag, " overrun_count"}, ovr_cnt, (en0 && second_at > 0) ? 1 : 0);
    if (en0 && second_at > 0) chk({tag, " overrun_timing"}, int'(ovr_at_second), 1);
    check_outputs(tag);
  endtask

  initial begin
    int upd_cnt;
    n_pass = 0;
    n_total = 0;
    //            cycle duty  phase rise  fall
    tv[0]  = '{5000, 2500, 2500, 1250, 3750};
    tv[1]  = '{5000, 1001,  200, 4700,  701};
    tv[2]  = '{5000, 1000, 4900, 4400,  400};
    tv[3]  = '{5000,    0,  100,  100,  100};
    tv[4]  = '{5000, 6000,    0,    0, 5000};
    tv[5]  = '{5000, 2000, 7000, 3999,  999};
    tv[6]  = '{5000, 5000,   10,    0, 5000};
    tv[7]  = '{5000, 4999,    0, 2501, 2500};
    tv[8]  = '{5000,    1, 4999, 4999,    0};
    tv[9]  = '{   0,  100,   50,    0,    0};
    tv[10] = '{5000,    0, 7000, 4999, 4999};
    tv[11] = '{8191, 8190, 8190, 4095, 4094};
    tv[12] = '{   3,    2,    1,    0,    2};

    rst_n  = 1'b1;
    enable = 1'b1;
    start  = 1'b0;
`ifdef PWM_PRECON_FORCE_OFF_EN
    force_off = 1'b0;
`endif
    load_inputs(0);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_zero();
    chk("reset update", int'(update), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(overrun), 0);
    check_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pass("basic", 0, 1'b1, 0, 0);
    run_pass("overrun", 5, 1'b1, 10, 0);
    run_pass("disabled", 3, 1'b0, 0, 0);
    run_pass("enable_drop", 9, 1'b1, 0, 20);

    // Reset in the middle of a pass: immediate clear, no commit afterwards.
    load_inputs(7);
    @(posedge clk); #1;
    start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (n == 3) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    expect_zero();
    chk("rst_mid update", int'(update), 0);
    chk("rst_mid busy", int'(busy), 0);
    check_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    upd_cnt = 0;
    for (int n = 0; n < DEPTH + 20; n++) begin
      @(posedge clk); #1;
      if (update) upd_cnt++;
    end
    chk("rst_mid no_update", upd_cnt, 0);
    check_outputs("rst_mid_after");

    run_pass("after_reset", 7, 1'b1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
